multicycle_controller: RTL

Sequencing FSM that drives a multicycle variant of the MIPS datapath (shared instruction/data memory, instruction register, ALU result register), replacing the single-cycle combinational decoder. It steps each instruction through fetch, decode, execute, memory and write-back states. It emits the mux selects, register write strobes, ALU operation and PC enable for the datapath. It also handles a `mem_ready` handshake so the shared memory may insert wait states.

---
 rtl/multicycle_controller.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/multicycle_controller.sv
// multicycle_controller: sequencing FSM for a multicycle MIPS datapath with
// a shared memory that may stretch FETCH, MEMRD and MEMWR via mem_ready.
module multicycle_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IorD,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [1:0] PCSrc,
    output logic       PCEn,
    output logic       illegal_op,
    output logic [3:0] state_o
);
    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        ADDIEX = 4'd9,
        ADDIWB = 4'd10,
        JUMP   = 4'd11
    } state_t;

    state_t state_q, state_d;
    logic   pc_write, branch;

    always_ff @(posedge clk or negedge reset)
        if (!reset) state_q <= FETCH;
        else        state_q <= state_d;

    assign state_o = state_q;

    always_comb begin
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        IorD       = 1'b0;
        IRWrite    = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ALUControl = 3'b010;
        PCSrc      = 2'b00;
        illegal_op = 1'b0;
        pc_write   = 1'b0;
        branch     = 1'b0;
        state_d    = FETCH;
        // While reset is held every strobe stays low, FETCH included.
        if (reset) begin
            case (state_q)
                FETCH: begin
                    MemRead  = 1'b1;
                    ALUSrcB  = 2'b01;
                    IRWrite  = mem_ready;
                    pc_write = mem_ready;
                    state_d  = mem_ready ? DECODE : FETCH;
                end
                DECODE: begin
                    ALUSrcB = 2'b11;
                    case (op)
                        6'b100011, 6'b101011: state_d = MEMADR;
                        6'b000000:            state_d = EXEC;
                        6'b000100:            state_d = BRANCH;
                        6'b001000:            state_d = ADDIEX;
                        6'b000010:            state_d = JUMP;
                        default:              illegal_op = 1'b1;
                    endcase
                end
                MEMADR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                    state_d = (op == 6'b100011) ? MEMRD : MEMWR;
                end
                MEMRD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                    state_d = mem_ready ? MEMWB : MEMRD;
                end
                MEMWB: begin
                    MemtoReg = 1'b1;
                    RegWrite = 1'b1;
                end
                MEMWR: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                    state_d  = mem_ready ? FETCH : MEMWR;
                end
                EXEC: begin
                    ALUSrcA = 1'b1;
                    state_d = ALUWB;
                    case (funct)
                        6'b100000: ALUControl = 3'b010;
                        6'b100010: ALUControl = 3'b110;
                        6'b100100: ALUControl = 3'b000;
                        6'b100101: ALUControl = 3'b001;
                        6'b101010: ALUControl = 3'b111;
                        default: begin
                            illegal_op = 1'b1;
                            state_d    = FETCH;
                        end
                    endcase
                end
                ALUWB: begin
                    RegDst   = 1'b1;
                    RegWrite = 1'b1;
                end
                BRANCH: begin
                    ALUSrcA    = 1'b1;
                    ALUControl = 3'b110;
                    PCSrc      = 2'b01;
                    branch     = 1'b1;
                end
                ADDIEX: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                    state_d = ADDIWB;
                end
                ADDIWB: RegWrite = 1'b1;
                JUMP: begin
                    PCSrc    = 2'b10;
                    pc_write = 1'b1;
                end
                default: state_d = FETCH;
            endcase
        end
        PCEn = pc_write | (branch & Zero);
    end
endmodule
